bias_z_writeback: RTL and testbench
===================================

// Module: bias_z_writeback
// PURPOSE
//  Downstream end of the bias stage: consumes the two per-column bias outputs (Z values + valids),
//  removes the one-cycle column skew inherited from the systolic array, and packs each row
//  {col2,col1} into a 32-bit word. Rows are buffered in a small FIFO and written to the unified
//  buffer over a valid/ready write port at incrementing addresses. Run length is set by start.
// PARAMETERS
//  DATA_W     16  width of one signed Z element (Q8.8)
//  FIFO_DEPTH 4   row FIFO entries (power of 2, >=2)
//  ADDR_W     8   unified-buffer word address width; also width of the row count
// PORTS
//  clk           in   1         clock, all state on rising edge
//  rst           in   1         asynchronous, active-low reset
//  start         in   1         1-cycle pulse: latch base_addr_in/num_rows_in, begin a run
//  base_addr_in  in   ADDR_W    first write address of the run
//  num_rows_in   in   ADDR_W    rows to write in this run
//  z_data_in_1   in   DATA_W    column-1 Z value, signed
//  z_valid_in_1  in   1         column-1 value valid
//  z_data_in_2   in   DATA_W    column-2 Z value, signed; arrives 1 cycle after its column-1 partner
//  z_valid_in_2  in   1         column-2 value valid
//  wr_valid      out  1         write request valid (FIFO not empty)
//  wr_ready      in   1         unified buffer accepts write this cycle
//  wr_addr       out  ADDR_W    write address
//  wr_data       out  2*DATA_W  {col2,col1}; col1 in [DATA_W-1:0]
//  busy          out  1         run in progress
//  done          out  1         1-cycle pulse when the last row of a run is accepted
//  skew_err      out  1         sticky: column pairing violated
//  overflow_err  out  1         sticky: row dropped, FIFO full
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, FIFO empty, hold_v=0, counters 0; all outputs 0.
//  FSM: IDLE -start-> RUN; RUN -(rows_written==num_rows)-> DONE; DONE -> IDLE (1 cycle).
//   - done=1 only in DONE; busy=1 in RUN. start with num_rows_in=0 -> RUN then DONE next cycle.
//   - start outside IDLE is ignored. start clears skew_err, overflow_err, rows_written,
//     loads wr_addr<=base_addr_in.
//  Deskew (RUN only; z_valid_in_* ignored without error in IDLE/DONE):
//   - z_valid_in_1: hold<=z_data_in_1, hold_v<=1.
//   - z_valid_in_2 & hold_v: push {z_data_in_2,hold}; hold_v<=0 unless z_valid_in_1 same cycle
//     (back-to-back streaming: push old pair and capture new col1 in one cycle).
//   - z_valid_in_2 & !hold_v: skew_err<=1, col2 dropped.
//   - z_valid_in_1 & hold_v & !z_valid_in_2: skew_err<=1, hold overwritten.
//  FIFO: push while full -> row dropped, overflow_err<=1, not counted. Push and pop in the
//   same cycle while full is allowed (pop frees the slot; no error). No pop on empty.
//  Write port: wr_valid=!empty; wr_data=FIFO head; wr_valid/wr_data/wr_addr stable until
//   wr_valid&wr_ready. On accept: pop, wr_addr+=1 (wraps mod 2^ADDR_W), rows_written+=1.
//  Latency: pair push on edge ending col2-valid cycle t; wr_valid=1 at t+1 if FIFO was empty.
//  Rows beyond num_rows arriving in RUN are still buffered; leaving RUN stops acceptance of new
//   inputs, but any queued rows keep draining through wr_* in IDLE (not counted).
//  Arithmetic: pure data movement, no rounding/saturation; sign bits preserved bit-exact.
// TESTING
//  1 Reset mid-run with 2 rows queued -> wr_valid=0, busy=0, errors 0 immediately (async).
//  2 start base=0x10 rows=2; col1=0x0100@t0, col2=0xFF00@t1, col1=0x0200@t1, col2=0x0080@t2,
//    wr_ready=1 -> writes {FF00,0100}@0x10, {0080,0200}@0x11; done pulses once; busy then 0.
//  3 wr_ready=0, stream 5 rows, DEPTH=4 -> 4 queued, overflow_err=1; release -> 4 writes, in order.
//  4 col2 valid with no preceding col1 -> skew_err=1, nothing pushed; next start clears it.
//  5 base=0xFF rows=2 -> writes at 0xFF then 0x00 (wrap).
//  6 start rows=0 -> done pulses 2 cycles after start, no writes; start during RUN ignored.

Source files
------------

// File: rtl/bias_z_writeback_if.sv
// Unified-buffer write port: valid/ready handshake carrying one packed row per beat.
// The writer holds valid, addr and data steady until ready is seen.
interface bias_z_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic                wr_valid;
  logic                wr_ready;
  logic [ADDR_W-1:0]   wr_addr;
  logic [2*DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/bias_z_writeback.sv
// Deskews the two bias columns into {col2,col1} rows, queues them and writes them out at incrementing addresses.
// Row reaches wr_valid one cycle after its col2 beat; wr_ready low stalls the queue and a push into a full queue drops the row.
module bias_z_writeback #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr_in,
  input  logic [ADDR_W-1:0]  num_rows_in,
  input  logic [DATA_W-1:0]  z_data_in_1,
  input  logic               z_valid_in_1,
  input  logic [DATA_W-1:0]  z_data_in_2,
  input  logic               z_valid_in_2,
  bias_z_writeback_if.master wr,
  output logic               busy,
  output logic               done,
  output logic               skew_err,
  output logic               overflow_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] col2;
    logic [DATA_W-1:0] col1;
  } row_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] num_rows, rows_written, addr_q;
  logic [DATA_W-1:0] hold;
  logic              hold_v;
  row_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;
  row_t              push_row;
  logic              run, start_ok, empty, full, pop;
  logic              push_req, push, drop, skew_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (rows_written == num_rows) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign run      = (state == RUN);
  assign start_ok = start && (state == IDLE);
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop      = wr.wr_valid && wr.wr_ready;

  // Col2 of a row lags its col1 by one cycle, so col1 waits in hold until its partner shows up.
  assign push_req = run && z_valid_in_2 && hold_v;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign skew_hit = run && ((z_valid_in_2 && !hold_v) ||
                            (z_valid_in_1 && hold_v && !z_valid_in_2));
  assign push_row = '{col2: z_data_in_2, col1: hold};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_row;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold   <= '0;
      hold_v <= 1'b0;
    end else if (start_ok) begin
      hold_v <= 1'b0;
    end else if (run) begin
      if (z_valid_in_1) begin
        hold   <= z_data_in_1;
        hold_v <= 1'b1;
      end else if (z_valid_in_2) begin
        hold_v <= 1'b0;
      end
    end
  end

  // Queued rows keep draining after the run ends; only rows accepted during RUN count toward num_rows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_rows     <= '0;
      rows_written <= '0;
      addr_q       <= '0;
      skew_err     <= 1'b0;
      overflow_err <= 1'b0;
    end else if (start_ok) begin
      num_rows     <= num_rows_in;
      rows_written <= '0;
      addr_q       <= base_addr_in;
      skew_err     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (pop) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (run) rows_written <= rows_written + ADDR_W'(1);
      end
      if (skew_hit) skew_err <= 1'b1;
      if (drop)     overflow_err <= 1'b1;
    end
  end

  assign wr.wr_valid = !empty;
  assign wr.wr_data  = mem[rd_ptr];
  assign wr.wr_addr  = addr_q;
endmodule

// File: tb/tb_bias_z_writeback.sv
// Directed bench for bias_z_writeback: a queue-level model is checked every cycle, plus literal expectations per scenario.
module tb_bias_z_writeback;
  localparam int DATA_W = 16, FIFO_DEPTH = 4, ADDR_W = 8;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0] base_addr_in = '0, num_rows_in = '0;
  logic [DATA_W-1:0] z_data_in_1 = '0, z_data_in_2 = '0;
  logic z_valid_in_1 = 1'b0, z_valid_in_2 = 1'b0;
  logic busy, done, skew_err, overflow_err;

  int vectors = 0, miscompares = 0;

  bias_z_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wr_bus ();

  bias_z_writeback #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr_in(base_addr_in), .num_rows_in(num_rows_in),
    .z_data_in_1(z_data_in_1), .z_valid_in_1(z_valid_in_1),
    .z_data_in_2(z_data_in_2), .z_valid_in_2(z_valid_in_2),
    .wr(wr_bus), .busy(busy), .done(done), .skew_err(skew_err), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 running, 2 finishing; queue holds the rows awaiting write.
  int          m_mode = 0;
  logic [31:0] mq[$];
  logic [15:0] m_hold = '0;
  bit          m_hold_v = 0, m_skew = 0, m_ovf = 0;
  logic [7:0]  m_addr = '0, m_rows = '0, m_num = '0;
  logic [7:0]  log_a[$];
  logic [31:0] log_d[$];
  int          done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int          sz;
    bit          pop, running, push;
    logic [31:0] pd;
    logic [7:0]  old_rows;
    if (!rst) begin
      m_mode = 0; mq.delete(); m_hold = '0; m_hold_v = 0;
      m_addr = '0; m_rows = '0; m_num = '0; m_skew = 0; m_ovf = 0;
      return;
    end
    sz       = mq.size();
    pop      = (sz != 0) && (wr_bus.wr_ready === 1'b1);
    running  = (m_mode == 1);
    old_rows = m_rows;
    push     = 0;
    pd       = '0;
    if (running) begin
      if (z_valid_in_2 && m_hold_v) begin push = 1; pd = {z_data_in_2, m_hold}; end
      if (z_valid_in_2 && !m_hold_v) m_skew = 1;
      if (z_valid_in_1 && m_hold_v && !z_valid_in_2) m_skew = 1;
      if (z_valid_in_1) begin m_hold = z_data_in_1; m_hold_v = 1; end
      else if (z_valid_in_2) m_hold_v = 0;
    end
    if (pop) begin
      void'(mq.pop_front());
      m_addr = m_addr + 8'd1;
      if (running) m_rows = m_rows + 8'd1;
    end
    if (push) begin
      if (sz == FIFO_DEPTH && !pop) m_ovf = 1;
      else mq.push_back(pd);
    end
    case (m_mode)
      0: if (start) begin
        m_mode = 1; m_num = num_rows_in; m_rows = '0; m_addr = base_addr_in;
        m_skew = 0; m_ovf = 0; m_hold_v = 0;
      end
      1: if (old_rows == m_num) m_mode = 2;
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_cycle();
    bit nonempty;
    nonempty = (mq.size() != 0);
    chk("wr_valid", wr_bus.wr_valid, nonempty);
    if (nonempty) begin
      chk("wr_data", wr_bus.wr_data, mq[0]);
      chk("wr_addr", wr_bus.wr_addr, m_addr);
    end
    chk("busy", busy, m_mode == 1);
    chk("done", done, m_mode == 2);
    chk("skew_err", skew_err, m_skew);
    chk("overflow_err", overflow_err, m_ovf);
    if (wr_bus.wr_valid === 1'b1 && wr_bus.wr_ready === 1'b1) begin
      log_a.push_back(wr_bus.wr_addr);
      log_d.push_back(wr_bus.wr_data);
    end
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] base, input logic [7:0] n);
    cyc();
    start = 1'b1; base_addr_in = base; num_rows_in = n;
  endtask

  task automatic drive(input bit v1, input logic [15:0] d1, input bit v2, input logic [15:0] d2);
    cyc();
    start = 1'b0;
    z_valid_in_1 = v1; z_data_in_1 = d1;
    z_valid_in_2 = v2; z_data_in_2 = d2;
  endtask

  task automatic wait_done(input string nm, input int max_cyc);
    bit got;
    got = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      settle();
      if (done === 1'b1) got = 1;
    end
    chk(nm, got, 1'b1);
  endtask

  initial begin
    int b, dc0;
    wr_bus.wr_ready = 1'b0;
    fork
      forever begin @(posedge clk or negedge rst); model_step(); end
      forever begin @(negedge clk); compare_cycle(); end
      begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    #3;
    chk("rst_wr_valid", wr_bus.wr_valid, 1'b0);
    chk("rst_wr_addr", wr_bus.wr_addr, 8'h00);
    chk("rst_wr_data", wr_bus.wr_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_errs", {skew_err, overflow_err}, 2'b00);
    cyc(); cyc();
    rst = 1'b1;

    // Async reset mid-run with two rows queued and a skew error raised
    start_run(8'h40, 8'd3);
    drive(1, 16'hAAAA, 0, 16'h0);
    drive(1, 16'hBBBB, 1, 16'h1111);
    drive(0, 16'h0, 1, 16'h2222);
    drive(0, 16'h0, 1, 16'h3333);
    drive(0, 16'h0, 0, 16'h0);
    settle();
    chk("t1_pre_wr_valid", wr_bus.wr_valid, 1'b1);
    chk("t1_pre_skew", skew_err, 1'b1);
    chk("t1_pre_head", wr_bus.wr_data, 32'h1111_AAAA);
    cyc();
    rst = 1'b0;
    #1;
    chk("t1_wr_valid", wr_bus.wr_valid, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_errs", {skew_err, overflow_err}, 2'b00);
    cyc(); cyc();
    rst = 1'b1;

    // Basic two-row run with streaming columns
    wr_bus.wr_ready = 1'b1;
    b = log_d.size(); dc0 = done_cnt;
    start_run(8'h10, 8'd2);
    drive(1, 16'h0100, 0, 16'h0);
    drive(1, 16'h0200, 1, 16'hFF00);
    drive(0, 16'h0, 1, 16'h0080);
    drive(0, 16'h0, 0, 16'h0);
    wait_done("t2_done_seen", 20);
    cyc(); cyc();
    settle();
    chk("t2_nwrites", log_d.size() - b, 2);
    if (log_d.size() >= b + 2) begin
      chk("t2_w0_addr", log_a[b], 8'h10);
      chk("t2_w0_data", log_d[b], 32'hFF00_0100);
      chk("t2_w1_addr", log_a[b+1], 8'h11);
      chk("t2_w1_data", log_d[b+1], 32'h0080_0200);
    end
    chk("t2_done_pulses", done_cnt - dc0, 1);
    chk("t2_busy_after", busy, 1'b0);

    // Five rows into a four-deep queue while the write port is stalled
    wr_bus.wr_ready = 1'b0;
    b = log_d.size();
    start_run(8'h20, 8'd4);
    drive(1, 16'h0001, 0, 16'h0);
    for (int i = 1; i < 5; i++) drive(1, 16'(i + 1), 1, 16'(16'h8000 + i - 1));
    drive(0, 16'h0, 1, 16'h8004);
    drive(0, 16'h0, 0, 16'h0);
    settle();
    chk("t3_overflow", overflow_err, 1'b1);
    chk("t3_wr_valid", wr_bus.wr_valid, 1'b1);
    cyc();
    wr_bus.wr_ready = 1'b1;
    wait_done("t3_done_seen", 20);
    chk("t3_nwrites", log_d.size() - b, 4);
    if (log_d.size() >= b + 4)
      for (int i = 0; i < 4; i++) begin
        chk("t3_addr", log_a[b+i], 8'(8'h20 + i));
        chk("t3_data", log_d[b+i], {16'(16'h8000 + i), 16'(i + 1)});
      end

    // Orphan col2 raises skew_err; a clean row then completes the run
    start_run(8'h30, 8'd1);
    drive(0, 16'h0, 1, 16'h5555);
    drive(0, 16'h0, 0, 16'h0);
    settle();
    chk("t4_skew", skew_err, 1'b1);
    chk("t4_nothing_pushed", wr_bus.wr_valid, 1'b0);
    drive(1, 16'h0101, 0, 16'h0);
    drive(0, 16'h0, 1, 16'h0202);
    drive(0, 16'h0, 0, 16'h0);
    wait_done("t4_done_seen", 20);

    // Address wrap; the new start also clears the sticky skew_err
    b = log_d.size();
    start_run(8'hFF, 8'd2);
    drive(1, 16'h1234, 0, 16'h0);
    settle();
    chk("t5_skew_cleared", skew_err, 1'b0);
    drive(1, 16'h5678, 1, 16'hCAFE);
    drive(0, 16'h0, 1, 16'hBEEF);
    drive(0, 16'h0, 0, 16'h0);
    wait_done("t5_done_seen", 20);
    chk("t5_nwrites", log_d.size() - b, 2);
    if (log_d.size() >= b + 2) begin
      chk("t5_w0_addr", log_a[b], 8'hFF);
      chk("t5_w0_data", log_d[b], 32'hCAFE_1234);
      chk("t5_w1_addr", log_a[b+1], 8'h00);
      chk("t5_w1_data", log_d[b+1], 32'hBEEF_5678);
    end

    // Zero-row run: done two cycles after start, a second start while running is ignored
    b = log_d.size();
    start_run(8'h50, 8'd0);
    cyc();
    start = 1'b1; base_addr_in = 8'h77; num_rows_in = 8'd5;
    settle();
    chk("t6_busy_run", busy, 1'b1);
    chk("t6_done_early", done, 1'b0);
    cyc();
    start = 1'b0;
    settle();
    chk("t6_done", done, 1'b1);
    chk("t6_busy_done", busy, 1'b0);
    cyc();
    settle();
    chk("t6_done_after", done, 1'b0);
    chk("t6_busy_after", busy, 1'b0);
    chk("t6_no_writes", log_d.size() - b, 0);

    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
